// File: rtl/imem_port_arbiter_pkg.sv
// Shared types for the instruction-memory port arbiter: state encoding, access record, widths.
package imem_port_arbiter_pkg;

    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned BE_W     = DATA_W / 8;
    localparam int unsigned STARVE_W = 8;

    typedef enum logic [3:0] {
        StFetch   = 4'b0001,
        StExt     = 4'b0010,
        StHoldIf  = 4'b0100,
        StHoldExt = 4'b1000
    } imem_arb_state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data_w;
        logic [BE_W-1:0]   be;
    } imem_access_t;

    // The response currently on mem_data_r belongs to the secondary requester.
    function automatic logic is_ext_owner(imem_arb_state_e s);
        return (s == StExt) || (s == StHoldExt);
    endfunction

endpackage

// File: rtl/imem_port_arbiter_if.sv
// Fetch, secondary-requester and RAM signals seen by the arbiter (slave) and its environment (master).
interface imem_port_arbiter_if;
    import imem_port_arbiter_pkg::*;

    logic              if_en;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_data_r;
    logic              if_delay;

    logic              ext_req;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_data_w;
    logic [BE_W-1:0]   ext_be;
    logic              ext_ack;
    logic [DATA_W-1:0] ext_data_r;
    logic              ext_rvalid;

    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_w;
    logic              mem_we;
    logic [BE_W-1:0]   mem_be;
    logic [DATA_W-1:0] mem_data_r;
    logic              mem_delay;

    modport slave (
        input  if_en, if_addr, ext_req, ext_we, ext_addr, ext_data_w, ext_be, mem_data_r, mem_delay,
        output if_data_r, if_delay, ext_ack, ext_data_r, ext_rvalid,
        output mem_en, mem_addr, mem_data_w, mem_we, mem_be
    );

    modport master (
        output if_en, if_addr, ext_req, ext_we, ext_addr, ext_data_w, ext_be, mem_data_r, mem_delay,
        input  if_data_r, if_delay, ext_ack, ext_data_r, ext_rvalid,
        input  mem_en, mem_addr, mem_data_w, mem_we, mem_be
    );

endinterface

// File: rtl/imem_arb_starve_ctr.sv
// Counts consecutive cycles the secondary requester lost to fetch; saturates at MAX_STARVE.
module imem_arb_starve_ctr
    import imem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_STARVE = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    logic [STARVE_W-1:0] cnt_q, cnt_d;

    assign at_max = (cnt_q == STARVE_W'(MAX_STARVE));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !at_max) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the imem RAM port between instruction fetch (default winner) and one secondary
// requester, with a starvation limit and stall re-drive while the RAM asserts mem_delay.
module imem_port_arbiter
    import imem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_STARVE = 8
) (
    input logic                clk,
    input logic                reset,
    imem_port_arbiter_if.slave bus
);

    imem_arb_state_e state_q;
    imem_access_t    acc_q, ext_acc, if_acc, mem_acc;
    logic            en_q, mem_en_c;
    logic            ext_owner, hold, at_max;
    logic            ext_grant, if_grant, starve_inc, starve_clr;

    assign ext_owner = is_ext_owner(state_q);
    assign hold      = bus.mem_delay;

    assign ext_grant  = !hold && bus.ext_req && (!bus.if_en || at_max);
    assign if_grant   = !hold && !ext_grant && bus.if_en;
    assign starve_clr = !hold && (ext_grant || !bus.ext_req);
    assign starve_inc = if_grant && bus.ext_req;

    assign ext_acc = '{we: bus.ext_we, addr: bus.ext_addr, data_w: bus.ext_data_w, be: bus.ext_be};
    assign if_acc  = '{we: 1'b0, addr: bus.if_addr, data_w: '0, be: '0};

    // While stalled the in-flight access is replayed from its registered copy.
    always_comb begin
        mem_acc  = '0;
        mem_en_c = 1'b0;
        if (hold) begin
            mem_acc  = acc_q;
            mem_en_c = en_q;
        end else if (ext_grant) begin
            mem_acc  = ext_acc;
            mem_en_c = 1'b1;
        end else if (if_grant) begin
            mem_acc  = if_acc;
            mem_en_c = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
            acc_q   <= '0;
            en_q    <= 1'b0;
        end else if (hold) begin
            state_q <= ext_owner ? StHoldExt : StHoldIf;
        end else begin
            state_q <= ext_grant ? StExt : StFetch;
            acc_q   <= mem_acc;
            en_q    <= mem_en_c;
        end
    end

    imem_arb_starve_ctr #(
        .MAX_STARVE(MAX_STARVE)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc   (starve_inc),
        .clr   (starve_clr),
        .at_max(at_max)
    );

    assign bus.mem_en     = mem_en_c && !reset;
    assign bus.mem_addr   = mem_acc.addr;
    assign bus.mem_we     = mem_acc.we;
    assign bus.mem_be     = mem_acc.be;
    assign bus.mem_data_w = mem_acc.data_w;

    assign bus.ext_ack    = ext_grant && !reset;
    assign bus.ext_rvalid = ext_owner && !hold && !acc_q.we;
    assign bus.ext_data_r = bus.mem_data_r;
    assign bus.if_data_r  = bus.mem_data_r;
    assign bus.if_delay   = !reset && (hold || ext_owner);

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed and randomized checks of imem_port_arbiter against a cycle-level behavioural model.
`define CHK(tag, o, e) chk(tag, 32'(o), 32'(e))

module tb_imem_port_arbiter;
    import imem_port_arbiter_pkg::*;

    localparam int unsigned MaxStarve = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    imem_port_arbiter_if bus ();

    imem_port_arbiter #(
        .MAX_STARVE(MaxStarve)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int   vectors = 0;
    int   miscompares = 0;
    logic last_ack = 1'b0;

    function automatic logic [31:0] init_word(int i);
        return 32'h1357_0000 + 32'(i) * 32'h0001_0203;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] w, logic [31:0] d, logic [3:0] be);
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
        return w;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural RAM: samples a request when issued and not stalled, data valid next cycle.
    logic [31:0] ram [1024];
    logic [31:0] ram_rdata;
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 1024; i++) ram[i] <= init_word(i);
            ram_rdata <= '0;
        end else if (bus.mem_en && !bus.mem_delay) begin
            ram_rdata <= ram[bus.mem_addr];
            if (bus.mem_we) ram[bus.mem_addr] <= merge(ram[bus.mem_addr], bus.mem_data_w, bus.mem_be);
        end
    end
    assign bus.mem_data_r = ram_rdata;

    // Reference model: who owns the response in flight, expected read word, starvation count.
    typedef enum {OwnNone, OwnFetch, OwnExt} owner_e;
    owner_e      m_own = OwnNone;
    logic        m_we = 1'b0;
    logic [9:0]  m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [3:0]  m_be = '0;
    logic [31:0] m_rexp = '0;
    logic [31:0] shadow [1024];
    int          m_starve = 0;
    logic        g_ext, g_if;

    initial begin : model
        forever begin
            @(negedge clk);
            if (reset) begin
                `CHK("rst_mem_en", bus.mem_en, 0);
                `CHK("rst_ext_ack", bus.ext_ack, 0);
                `CHK("rst_rvalid", bus.ext_rvalid, 0);
                `CHK("rst_if_delay", bus.if_delay, 0);
                m_own    = OwnNone;
                m_starve = 0;
                last_ack = 1'b0;
                for (int i = 0; i < 1024; i++) shadow[i] = init_word(i);
            end else begin
                vectors++;
                if (bus.if_data_r !== bus.mem_data_r) begin
                    miscompares++;
                    $error("FAIL if_data_r observed=%0h expected=%0h", bus.if_data_r,
                           bus.mem_data_r);
                end
                vectors++;
                if (bus.ext_data_r !== bus.mem_data_r) begin
                    miscompares++;
                    $error("FAIL ext_data_r observed=%0h expected=%0h", bus.ext_data_r,
                           bus.mem_data_r);
                end
                if (bus.mem_delay) begin
                    `CHK("hold_mem_en", bus.mem_en, m_own != OwnNone);
                    if (m_own != OwnNone) begin
                        `CHK("hold_addr", bus.mem_addr, m_addr);
                        `CHK("hold_we", bus.mem_we, m_we);
                        `CHK("hold_be", bus.mem_be, m_be);
                        `CHK("hold_wdata", bus.mem_data_w, m_wdata);
                    end
                    `CHK("hold_ext_ack", bus.ext_ack, 0);
                    `CHK("hold_rvalid", bus.ext_rvalid, 0);
                    `CHK("hold_if_delay", bus.if_delay, 1);
                    last_ack = 1'b0;
                end else begin
                    `CHK("rvalid", bus.ext_rvalid, m_own == OwnExt && !m_we);
                    `CHK("if_delay", bus.if_delay, m_own == OwnExt);
                    if (m_own == OwnExt && !m_we) `CHK("ext_rdata", bus.ext_data_r, m_rexp);
                    if (m_own == OwnFetch) `CHK("if_rdata", bus.if_data_r, m_rexp);
                    g_ext = bus.ext_req && (!bus.if_en || m_starve >= MaxStarve);
                    g_if  = !g_ext && bus.if_en;
                    `CHK("ext_ack", bus.ext_ack, g_ext);
                    `CHK("mem_en", bus.mem_en, g_ext || g_if);
                    if (g_ext) begin
                        m_own = OwnExt;  m_we = bus.ext_we; m_addr = bus.ext_addr;
                        m_wdata = bus.ext_data_w; m_be = bus.ext_be;
                    end else if (g_if) begin
                        m_own = OwnFetch; m_we = 1'b0; m_addr = bus.if_addr; m_wdata = '0; m_be = '0;
                    end else begin
                        m_own = OwnNone;
                    end
                    if (m_own != OwnNone) begin
                        `CHK("mem_addr", bus.mem_addr, m_addr);
                        `CHK("mem_we", bus.mem_we, m_we);
                        `CHK("mem_be", bus.mem_be, m_be);
                        `CHK("mem_wdata", bus.mem_data_w, m_wdata);
                        m_rexp = shadow[m_addr];
                        if (m_we) shadow[m_addr] = merge(shadow[m_addr], m_wdata, m_be);
                    end
                    if (g_ext || !bus.ext_req) m_starve = 0;
                    else if (m_starve < MaxStarve) m_starve++;
                    last_ack = g_ext;
                end
            end
        end
    end

    task automatic starve_run(string tag, logic [9:0] a);
        int n = 0;
        bus.if_en = 1'b1; bus.ext_req = 1'b1; bus.ext_we = 1'b0; bus.ext_addr = a;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.ext_ack) begin
                n = i;
                break;
            end
            tick();
        end
        `CHK(tag, n, MaxStarve + 1);
        tick();
        bus.ext_req = 1'b0;
    endtask

    initial begin
        bus.if_en = 0; bus.if_addr = '0; bus.ext_req = 0; bus.ext_we = 0; bus.ext_addr = '0;
        bus.ext_data_w = '0; bus.ext_be = '0; bus.mem_delay = 0;
        tick(); tick();
        reset = 1'b0;

        // fetch only
        for (int i = 0; i < 6; i++) begin
            bus.if_en = 1'b1; bus.if_addr = 10'(i);
            @(negedge clk);
            `CHK("fetch_addr", bus.mem_addr, i);
            `CHK("fetch_no_ack", bus.ext_ack, 0);
            tick();
        end

        // idle steal
        bus.if_en = 1'b0; bus.ext_req = 1'b1; bus.ext_we = 1'b0; bus.ext_addr = 10'h10;
        @(negedge clk); `CHK("idle_ack", bus.ext_ack, 1);
        tick();
        bus.ext_req = 1'b0; bus.if_en = 1'b1; bus.if_addr = 10'h5;
        @(negedge clk);
        `CHK("idle_rvalid", bus.ext_rvalid, 1);
        `CHK("idle_rdata", bus.ext_data_r, init_word(16));
        `CHK("idle_fetch_addr", bus.mem_addr, 10'h5);
        tick();
        @(negedge clk); `CHK("resume_if_delay", bus.if_delay, 0);
        tick();

        // starvation
        bus.if_addr = 10'h6;
        starve_run("starve_ack_cycle", 10'h30);
        @(negedge clk);
        `CHK("starve_if_delay", bus.if_delay, 1);
        `CHK("starve_refetch", bus.mem_addr, 10'h6);
        `CHK("starve_rvalid", bus.ext_rvalid, 1);
        tick();

        // RAM stall after ext read grant
        bus.if_en = 1'b0; bus.ext_req = 1'b1; bus.ext_addr = 10'h11;
        @(negedge clk); `CHK("dly_ack", bus.ext_ack, 1);
        tick();
        bus.ext_req = 1'b0; bus.if_en = 1'b1; bus.mem_delay = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            `CHK("dly_addr", bus.mem_addr, 10'h11);
            `CHK("dly_no_ack", bus.ext_ack, 0);
            `CHK("dly_if_delay", bus.if_delay, 1);
            `CHK("dly_no_rvalid", bus.ext_rvalid, 0);
            tick();
        end
        bus.mem_delay = 1'b0;
        @(negedge clk);
        `CHK("dly_rvalid", bus.ext_rvalid, 1);
        `CHK("dly_if_delay_end", bus.if_delay, 1);
        tick();

        // write then read
        bus.if_en = 1'b0; bus.ext_req = 1'b1; bus.ext_we = 1'b1; bus.ext_addr = 10'h20;
        bus.ext_data_w = 32'hDEAD_BEEF; bus.ext_be = 4'hF;
        @(negedge clk); `CHK("wr_ack", bus.ext_ack, 1);
        tick();
        bus.ext_we = 1'b0;
        @(negedge clk);
        `CHK("rd_ack", bus.ext_ack, 1);
        `CHK("wr_no_rvalid", bus.ext_rvalid, 0);
        tick();
        bus.ext_req = 1'b0;
        @(negedge clk);
        `CHK("rd_rvalid", bus.ext_rvalid, 1);
        `CHK("rd_data", bus.ext_data_r, 32'hDEAD_BEEF);
        tick();

        // reset while the ext read is stalled
        bus.ext_req = 1'b1; bus.ext_addr = 10'h12;
        @(negedge clk); `CHK("rst_pre_ack", bus.ext_ack, 1);
        tick();
        bus.ext_req = 1'b0; bus.mem_delay = 1'b1;
        @(negedge clk); `CHK("rst_hold_rvalid", bus.ext_rvalid, 0);
        tick();
        reset = 1'b1;
        @(negedge clk);
        `CHK("rst_mid_mem_en", bus.mem_en, 0);
        `CHK("rst_mid_if_delay", bus.if_delay, 0);
        tick();
        reset = 1'b0; bus.mem_delay = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); `CHK("rst_post_rvalid", bus.ext_rvalid, 0);
            tick();
        end

        // build up starvation, reset, then the full wait must be needed again
        bus.if_en = 1'b1; bus.ext_req = 1'b1; bus.ext_addr = 10'h13;
        repeat (4) tick();
        bus.ext_req = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        starve_run("starve_after_reset", 10'h14);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            bus.mem_delay = ($urandom_range(0, 3) == 0);
            bus.if_en     = ($urandom_range(0, 3) != 0);
            bus.if_addr   = 10'($urandom_range(0, 63));
            if (!bus.ext_req || last_ack) begin
                bus.ext_req    = ($urandom_range(0, 2) == 0);
                bus.ext_we     = 1'($urandom_range(0, 1));
                bus.ext_addr   = 10'($urandom_range(0, 63));
                bus.ext_data_w = $urandom;
                bus.ext_be     = 4'($urandom_range(0, 15));
            end
            tick();
        end

        bus.ext_req = 1'b0; bus.if_en = 1'b0; bus.mem_delay = 1'b0;
        tick(); tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
